// File: rtl/decoder_op_xbit_seq.sv
// Sequencer for CB-prefix bit operations: captures one opcode, strobes register
// operands for a single cycle and runs (HL) operands as a read/exec/write memory sequence.
module decoder_op_xbit_seq #(
  parameter int RSEL_W = 3,
  parameter int HL_IDX = 6,
  parameter logic [(2**RSEL_W)-1:0] INVERT_MASK = 8'b1001_0101,
  parameter int TIMEOUT = 15,
  localparam int NREG = 2**RSEL_W,
  localparam int OP_W = RSEL_W + 5
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            op_valid,
  input  logic [OP_W-1:0] op_code,
  output logic            op_ready,
  input  logic            mem_ack,
  output logic            mem_rd_req,
  output logic            mem_wr_req,
  output logic [NREG-1:0] reg_write,
  output logic [NREG-1:0] reg_sel_low,
  output logic [NREG-1:0] reg_sel_high,
  output logic            invert_in,
  output logic [1:0]      alu_class,
  output logic [2:0]      alu_bit,
  output logic            mem_operand,
  output logic            busy,
  output logic            done,
  output logic            mem_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [RSEL_W-1:0] HL_SEL = HL_IDX[RSEL_W-1:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC_R,
    S_MEM_RD,
    S_EXEC_M,
    S_MEM_WR
  } state_t;

  state_t            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [1:0]        cls;
  logic [RSEL_W-1:0] rsel;
  logic [NREG-1:0]   onehot;
  logic              wait_expired;

  assign cls          = op_q[OP_W-1 -: 2];
  assign rsel         = op_q[RSEL_W-1:0];
  assign onehot       = NREG'(1) << rsel;
  assign wait_expired = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cnt_d        = (cnt_q == CNT_W'(TIMEOUT)) ? cnt_q : cnt_q + CNT_W'(1);
    op_ready     = 1'b0;
    mem_rd_req   = 1'b0;
    mem_wr_req   = 1'b0;
    reg_write    = '0;
    reg_sel_low  = '0;
    reg_sel_high = '0;
    invert_in    = 1'b0;
    mem_operand  = 1'b0;
    done         = 1'b0;
    mem_timeout  = 1'b0;

    case (state_q)
      S_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          op_d    = op_code;
          state_d = (op_code[RSEL_W-1:0] == HL_SEL) ? S_MEM_RD : S_EXEC_R;
        end
      end
      S_EXEC_R: begin
        if (cls == 2'b00) reg_sel_low  = onehot;
        else              reg_sel_high = onehot;
        invert_in = INVERT_MASK[rsel];
        // BIT only updates flags, so it never writes the register back
        if (cls != 2'b01) reg_write = onehot & ~(NREG'(1) << HL_SEL);
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_MEM_RD: begin
        mem_rd_req = 1'b1;
        if (mem_ack) begin
          state_d = S_EXEC_M;
        end else if (wait_expired) begin
          mem_timeout = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_EXEC_M: begin
        mem_operand = 1'b1;
        if (cls == 2'b01) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_MEM_WR;
        end
      end
      S_MEM_WR: begin
        mem_wr_req = 1'b1;
        if (mem_ack) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end else if (wait_expired) begin
          mem_timeout = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  assign busy      = (state_q != S_IDLE);
  assign alu_class = cls;
  assign alu_bit   = op_q[RSEL_W +: 3];

endmodule

// File: tb/tb_decoder_op_xbit_seq.sv
// Bench for decoder_op_xbit_seq: a transaction model expands each opcode and ack
// schedule into per-cycle stimulus plus expected outputs, replayed and compared every cycle.
module tb_decoder_op_xbit_seq;

  localparam int TO = 4;
  localparam int HL = 6;
  localparam logic [7:0] MASK = 8'b1001_0101;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       op_valid;
  logic [7:0] op_code;
  logic       op_ready;
  logic       mem_ack;
  logic       mem_rd_req;
  logic       mem_wr_req;
  logic [7:0] reg_write;
  logic [7:0] reg_sel_low;
  logic [7:0] reg_sel_high;
  logic       invert_in;
  logic [1:0] alu_class;
  logic [2:0] alu_bit;
  logic       mem_operand;
  logic       busy;
  logic       done;
  logic       mem_timeout;

  decoder_op_xbit_seq #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET), .op_valid(op_valid), .op_code(op_code),
    .op_ready(op_ready), .mem_ack(mem_ack), .mem_rd_req(mem_rd_req),
    .mem_wr_req(mem_wr_req), .reg_write(reg_write), .reg_sel_low(reg_sel_low),
    .reg_sel_high(reg_sel_high), .invert_in(invert_in), .alu_class(alu_class),
    .alu_bit(alu_bit), .mem_operand(mem_operand), .busy(busy), .done(done),
    .mem_timeout(mem_timeout)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [7:0] code;
    logic       ack;
    logic       rdy, rd, wr, inv, mop, bsy, dn, to;
    logic [7:0] wr_s, lo, hi;
    logic [1:0] cls;
    logic [2:0] bt;
    int         tag;
    bit         acc;
  } cyc_t;

  cyc_t       q[$];
  logic [7:0] cur_code = 8'h00;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc_no = 0;

  function automatic cyc_t idle_cyc();
    cyc_t c;
    c.rst = 0; c.vld = 0; c.code = 8'($urandom); c.ack = 1'($urandom);
    c.rdy = 1; c.rd = 0; c.wr = 0; c.inv = 0; c.mop = 0; c.bsy = 0; c.dn = 0; c.to = 0;
    c.wr_s = 0; c.lo = 0; c.hi = 0;
    c.cls = cur_code[7:6]; c.bt = cur_code[5:3];
    c.tag = 0; c.acc = 0;
    return c;
  endfunction

  // Any op_valid offered while busy must be ignored
  function automatic cyc_t busy_cyc();
    cyc_t c;
    c = idle_cyc();
    c.rdy = 0; c.bsy = 1; c.vld = 1'($urandom); c.ack = 0;
    return c;
  endfunction

  task automatic push_reset(input int n);
    cyc_t c;
    cur_code = 8'h00;
    for (int i = 0; i < n; i++) begin
      c = idle_cyc();
      c.rst = 1; c.vld = 1'($urandom);
      q.push_back(c);
    end
  endtask

  // One memory request phase: ack arrives after d idle req cycles, unless the
  // wait runs out first or a reset is injected at req cycle rst_at.
  task automatic req_phase(input bit is_wr, input int d, input int rst_at,
                           input int tag, output bit acked);
    cyc_t c;
    acked = 0;
    for (int i = 0; i < TO; i++) begin
      if (i == rst_at) begin
        push_reset(1);
        return;
      end
      c = busy_cyc();
      c.rd = !is_wr; c.wr = is_wr;
      if (i == d) begin
        c.ack = 1; c.dn = is_wr; c.tag = is_wr ? tag : 0;
        q.push_back(c);
        acked = 1;
        return;
      end
      if (i == TO - 1) begin
        c.to = 1; c.tag = tag;
        q.push_back(c);
        return;
      end
      q.push_back(c);
    end
  endtask

  task automatic gen_op(input logic [7:0] code, input int a, input int b,
                        input int gap, input int rst_wr, input int tag);
    cyc_t c;
    bit ok;
    logic [2:0] rsel;
    logic [1:0] cls;
    logic [7:0] oh;
    c = idle_cyc();
    c.vld = 1; c.code = code; c.acc = 1;
    q.push_back(c);
    cur_code = code;
    rsel = code[2:0];
    cls = code[7:6];
    oh = 8'd1 << rsel;
    if (rsel != 3'(HL)) begin
      c = busy_cyc();
      c.ack = 1'($urandom);
      if (cls == 2'b00) c.lo = oh; else c.hi = oh;
      c.inv = MASK[rsel];
      c.wr_s = (cls == 2'b01) ? 8'h00 : oh;
      c.dn = 1; c.tag = tag;
      q.push_back(c);
    end else begin
      req_phase(0, a, -1, tag, ok);
      if (ok) begin
        c = busy_cyc();
        c.ack = 1'($urandom);
        c.mop = 1;
        if (cls == 2'b01) begin
          c.dn = 1; c.tag = tag;
          q.push_back(c);
        end else begin
          q.push_back(c);
          req_phase(1, b, rst_wr, tag, ok);
        end
      end
    end
    for (int i = 0; i < gap; i++) q.push_back(idle_cyc());
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", nm, cyc_no, act, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc_t c;
    int since_acc;
    logic [7:0] code;
    int rst_at;

    RESET = 1; op_valid = 0; op_code = 0; mem_ack = 0;
    since_acc = 0;

    push_reset(3);
    gen_op(8'h00, 0, 0, 0, -1, 1);
    gen_op(8'h5B, 0, 0, 1, -1, 2);
    gen_op(8'hFE, 2, 2, 1, -1, 3);
    gen_op(8'h46, 0, 0, 1, -1, 4);
    gen_op(8'h86, 9, 0, 1, -1, 5);
    gen_op(8'hC6, TO - 1, TO - 1, 0, -1, 0);
    gen_op(8'hFE, 1, 9, 1, 1, 0);
    gen_op(8'hBE, 0, 9, 1, -1, 0);
    for (int n = 0; n < 150; n++) begin
      code = 8'($urandom);
      if ($urandom_range(0, 2) == 0) code[2:0] = 3'(HL);
      rst_at = ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, 2)) : -1;
      gen_op(code, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
             int'($urandom_range(0, 2)), rst_at, 0);
    end

    while (q.size() > 0) begin
      @(negedge CLK);
      c = q.pop_front();
      RESET = c.rst; op_valid = c.vld; op_code = c.code; mem_ack = c.ack;
      #1;
      since_acc = c.acc ? 0 : since_acc + 1;
      chk("op_ready", 8'(op_ready), 8'(c.rdy));
      chk("busy", 8'(busy), 8'(c.bsy));
      chk("mem_rd_req", 8'(mem_rd_req), 8'(c.rd));
      chk("mem_wr_req", 8'(mem_wr_req), 8'(c.wr));
      chk("reg_write", reg_write, c.wr_s);
      chk("reg_sel_low", reg_sel_low, c.lo);
      chk("reg_sel_high", reg_sel_high, c.hi);
      chk("invert_in", 8'(invert_in), 8'(c.inv));
      chk("alu_class", 8'(alu_class), 8'(c.cls));
      chk("alu_bit", 8'(alu_bit), 8'(c.bt));
      chk("mem_operand", 8'(mem_operand), 8'(c.mop));
      chk("done", 8'(done), 8'(c.dn));
      chk("mem_timeout", 8'(mem_timeout), 8'(c.to));
      case (c.tag)
        1: begin
          chk("rlc_b_sel_low", reg_sel_low, 8'h01);
          chk("rlc_b_reg_write", reg_write, 8'h01);
          chk("rlc_b_invert", 8'(invert_in), 8'h01);
          chk("rlc_b_done", 8'(done), 8'h01);
        end
        2: begin
          chk("bit3e_sel_high", reg_sel_high, 8'h08);
          chk("bit3e_reg_write", reg_write, 8'h00);
          chk("bit3e_class", 8'(alu_class), 8'h01);
          chk("bit3e_bit", 8'(alu_bit), 8'h03);
        end
        3: begin
          chk("set7hl_done", 8'(done), 8'h01);
          chk("set7hl_wr_req", 8'(mem_wr_req), 8'h01);
          chk("set7hl_latency", 8'(since_acc), 8'd7);
        end
        4: begin
          chk("bit0hl_done", 8'(done), 8'h01);
          chk("bit0hl_operand", 8'(mem_operand), 8'h01);
          chk("bit0hl_latency", 8'(since_acc), 8'd2);
        end
        5: begin
          chk("timeout_pulse", 8'(mem_timeout), 8'h01);
          chk("timeout_no_done", 8'(done), 8'h00);
          chk("timeout_latency", 8'(since_acc), 8'd4);
        end
        default: ;
      endcase
      cyc_no++;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
